// File: rtl/qubit_pulse_tx.sv
// qubit_pulse_tx: transmit end of the 4-wire active-low qubit PMOD link.
// Measured bits are buffered in a small FIFO and sent as timed low pulses on
// the matching count line; a clear request sends a pulse on both reset lines.
// Optional far-end LED model output enabled by defining QUBIT_PULSE_TX_MIRROR_EN.
module qubit_pulse_tx #(
    parameter int PULSE_W    = 4,
    parameter int GAP_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk0,
    input  logic                          rst0,
    input  logic                          meas_valid,
    input  logic                          meas_bit,
    output logic                          meas_ready,
    input  logic                          clr_req,
    output logic                          clr_ack,
    output logic [3:0]                    qubit_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              sent0_cnt,
    output logic [CNT_W-1:0]              sent1_cnt
`ifdef QUBIT_PULSE_TX_MIRROR_EN
    ,
    output logic [3:0]                    mirror_led
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2((PULSE_W > GAP_W ? PULSE_W : GAP_W) + 1);

    typedef enum logic [2:0] {IDLE, PULSE, GAP, CLR_PULSE, CLR_GAP} state_t;

    state_t        state;
    logic [TW-1:0] tmr;
    logic          clr_pending;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          mem [FIFO_DEPTH];
    logic          push;
    logic          pop;
    logic          flush;
    logic          slot;
    logic          start_clr;
    logic          clr_done;
    logic          idle_nxt;
    logic          pending_nxt;
    logic [LW-1:0] level_nxt;

    // slot: the FSM may launch a new pulse (idle, or the last gap cycle)
    assign push        = meas_valid & meas_ready;
    assign flush       = clr_req & ~clr_pending;
    assign slot        = (state == IDLE) || (state == GAP && tmr == '0);
    assign start_clr   = slot & clr_pending;
    assign pop         = slot & ~clr_pending & (fifo_level != '0);
    assign clr_done    = (state == CLR_GAP) && (tmr == '0);
    assign pending_nxt = flush | (clr_pending & ~clr_done);
    assign level_nxt   = flush ? '0 : fifo_level + LW'(push) - LW'(pop);
    assign idle_nxt    = (slot & ~start_clr & ~pop) | clr_done;

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk0) begin
        if (push) mem[wr_ptr] <= meas_bit;
    end

    // FIFO pointers and level; a new clear request discards everything queued
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_level <= level_nxt;
        end
    end

    // Handshake and status flags registered from next-state values
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            meas_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            meas_ready <= (level_nxt != LW'(FIFO_DEPTH)) & ~pending_nxt;
            busy       <= ~idle_nxt | (level_nxt != '0);
        end
    end

    // Pulse sequencer: data pulse/gap and clear pulse/gap with registered lines
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state       <= IDLE;
            tmr         <= '0;
            qubit_n     <= 4'b1111;
            clr_pending <= 1'b0;
            clr_ack     <= 1'b0;
            sent0_cnt   <= '0;
            sent1_cnt   <= '0;
`ifdef QUBIT_PULSE_TX_MIRROR_EN
            mirror_led  <= 4'd0;
`endif
        end else begin
            clr_ack     <= clr_done;
            clr_pending <= pending_nxt;
            if (start_clr) begin
                state   <= CLR_PULSE;
                tmr     <= TW'(PULSE_W - 1);
                qubit_n <= 4'b1100;
`ifdef QUBIT_PULSE_TX_MIRROR_EN
                mirror_led <= 4'd0;
`endif
            end else if (pop) begin
                state   <= PULSE;
                tmr     <= TW'(PULSE_W - 1);
                qubit_n <= mem[rd_ptr] ? 4'b0111 : 4'b1011;
                if (mem[rd_ptr]) sent1_cnt <= sent1_cnt + 1'b1;
                else             sent0_cnt <= sent0_cnt + 1'b1;
`ifdef QUBIT_PULSE_TX_MIRROR_EN
                mirror_led <= mem[rd_ptr] ? mirror_led + 4'd1 : mirror_led - 4'd1;
`endif
            end else if (clr_done) begin
                state     <= IDLE;
                sent0_cnt <= '0;
                sent1_cnt <= '0;
            end else if ((state == PULSE || state == CLR_PULSE) && tmr == '0) begin
                state   <= (state == PULSE) ? GAP : CLR_GAP;
                tmr     <= TW'(GAP_W - 1);
                qubit_n <= 4'b1111;
            end else if (state == GAP && tmr == '0) begin
                state <= IDLE;
            end else if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qubit_pulse_tx.sv
// tb_qubit_pulse_tx: vector table plus directed sequences for qubit_pulse_tx,
// with a line monitor that pops expected bits from a scoreboard queue.
module tb_qubit_pulse_tx;
    localparam int PULSE_W = 4;
    localparam int GAP_W   = 4;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        meas_valid = 1'b0;
    logic        meas_bit = 1'b0;
    logic        clr_req = 1'b0;
    logic        meas_ready;
    logic        clr_ack;
    logic [3:0]  qubit_n;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [15:0] sent0_cnt;
    logic [15:0] sent1_cnt;
`ifdef QUBIT_PULSE_TX_MIRROR_EN
    logic [3:0]  mirror_led;
`endif

    qubit_pulse_tx #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk0(clk0), .rst0(rst0), .meas_valid(meas_valid), .meas_bit(meas_bit),
        .meas_ready(meas_ready), .clr_req(clr_req), .clr_ack(clr_ack),
        .qubit_n(qubit_n), .busy(busy), .fifo_level(fifo_level),
        .sent0_cnt(sent0_cnt), .sent1_cnt(sent1_cnt)
`ifdef QUBIT_PULSE_TX_MIRROR_EN
        , .mirror_led(mirror_led)
`endif
    );

    always #5 clk0 = ~clk0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int lo_len = 0;
    int hi_len = GAP_W;
    int pulse_cnt = 0;
    int clr_seen = 0;
    logic [3:0] prev_q = 4'hF;
    logic sb[$];
    int starts[$];

    typedef struct {
        logic [7:0] bits;
        int         n;
        int         exp0;
        int         exp1;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    always @(posedge clk0) cyc++;

    // line monitor: pulse widths, gaps, and bit order against the scoreboard
    always @(negedge clk0) begin
        logic exp_b;
        if (rst0) begin
            prev_q = 4'hF;
            lo_len = 0;
            hi_len = GAP_W;
        end else begin
            if (clr_ack) chk("clr_gap_len", hi_len, GAP_W);
            if (qubit_n != prev_q) begin
                if (prev_q == 4'hF) begin
                    chk("gap_min", hi_len >= GAP_W, 1);
                    if (qubit_n == 4'b1100) begin
                        clr_seen++;
                        sb.delete();
                    end else if (sb.size() == 0) begin
                        chk("sb_size_at_pulse", sb.size(), 1);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("pulse_line", qubit_n, exp_b ? 4'b0111 : 4'b1011);
                        pulse_cnt++;
                        starts.push_back(cyc);
                    end
                end else if (qubit_n == 4'hF) begin
                    chk(prev_q == 4'b1100 ? "clr_pulse_len" : "pulse_len", lo_len, PULSE_W);
                end else begin
                    chk("line_change", qubit_n, 4'hF);
                end
                lo_len = 0;
                hi_len = 0;
            end
            if (qubit_n == 4'hF) hi_len++;
            else lo_len++;
            prev_q = qubit_n;
        end
    end

    task automatic do_reset();
        meas_valid = 1'b0;
        meas_bit   = 1'b0;
        clr_req    = 1'b0;
        rst0       = 1'b1;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        #1;
        sb.delete();
        starts.delete();
        pulse_cnt = 0;
        clr_seen  = 0;
        rst0      = 1'b0;
        chk("rst_qubit_n", qubit_n, 4'hF);
        chk("rst_ready", meas_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sent0", sent0_cnt, 0);
        chk("rst_sent1", sent1_cnt, 0);
        chk("rst_clr_ack", clr_ack, 0);
    endtask

    task automatic push_bit(input logic b);
        logic rdy;
        bit   done;
        done       = 1'b0;
        meas_valid = 1'b1;
        meas_bit   = b;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = meas_ready;
            @(posedge clk0);
            #1;
            if (rdy) begin
                sb.push_back(b);
                done = 1'b1;
            end
        end
        meas_valid = 1'b0;
        chk("push_accept", done, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk0);
            #1;
            if (!busy) ok = 1'b1;
        end
        chk("idle_reached", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        bit got;
        int ones;
        vecs[0] = '{8'h00, 4, 4, 0};
        vecs[1] = '{8'hFF, 5, 0, 5};
        vecs[2] = '{8'hA5, 8, 4, 4};
        vecs[3] = '{8'h01, 1, 0, 1};
        vecs[4] = '{8'h36, 6, 2, 4};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) push_bit(vecs[v].bits[i]);
            wait_idle();
            chk("vec_sent0", sent0_cnt, vecs[v].exp0);
            chk("vec_sent1", sent1_cnt, vecs[v].exp1);
            chk("vec_level", fifo_level, 0);
            chk("vec_sb_drained", sb.size(), 0);
        end

        // single bit: exact pulse timing
        do_reset();
        push_bit(1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk0);
            #1;
            chk("single_line", qubit_n, i <= PULSE_W ? 4'b0111 : 4'b1111);
        end
        chk("single_sent1", sent1_cnt, 1);
        chk("single_sent0", sent0_cnt, 0);
        wait_idle();

        // back-to-back: exact period
        do_reset();
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b0);
        wait_idle();
        chk("b2b_pulses", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("b2b_period1", starts[1] - starts[0], PULSE_W + GAP_W);
            chk("b2b_period2", starts[2] - starts[1], PULSE_W + GAP_W);
        end
        chk("b2b_sent0", sent0_cnt, 2);
        chk("b2b_sent1", sent1_cnt, 1);
        chk("b2b_level", fifo_level, 0);

        // full FIFO: ready falls at level 8, nothing lost
        do_reset();
        pat = 10'b1101001110;
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(pat[i]);
        for (int i = 0; i < 9; i++) push_bit(pat[i]);
        chk("full_level", fifo_level, 8);
        chk("full_ready", meas_ready, 0);
        push_bit(pat[9]);
        wait_idle();
        chk("full_pulses", pulse_cnt, 10);
        chk("full_sent1", sent1_cnt, ones);
        chk("full_sent0", sent0_cnt, 10 - ones);

        // clear mid-stream during the 2nd pulse
        do_reset();
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk0);
            #1;
            if (pulse_cnt == 2) got = 1'b1;
        end
        chk("clr_second_pulse", got, 1);
        clr_req = 1'b1;
        @(posedge clk0);
        #1;
        clr_req = 1'b0;
        chk("clr_flush_level", fifo_level, 0);
        chk("clr_ready_low", meas_ready, 0);
        chk("clr_busy", busy, 1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk0);
            #1;
            if (clr_ack) got = 1'b1;
        end
        chk("clr_ack_seen", got, 1);
        chk("clr_sent0", sent0_cnt, 0);
        chk("clr_sent1", sent1_cnt, 0);
        chk("clr_pulses", pulse_cnt, 2);
        chk("clr_pattern_seen", clr_seen, 1);
`ifdef QUBIT_PULSE_TX_MIRROR_EN
        chk("clr_mirror", mirror_led, 0);
`endif
        @(posedge clk0);
        #1;
        chk("clr_ack_one_cycle", clr_ack, 0);
        chk("clr_ready_back", meas_ready, 1);
        chk("clr_idle", busy, 0);

        // async reset mid-pulse
        do_reset();
        push_bit(1'b0);
        push_bit(1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (qubit_n == 4'b1011) got = 1'b1;
            else begin
                @(negedge clk0);
                #1;
            end
        end
        chk("arst_in_pulse", got, 1);
        #1;
        rst0 = 1'b1;
        #1;
        chk("arst_qubit_n", qubit_n, 4'hF);
        chk("arst_level", fifo_level, 0);
        chk("arst_sent0", sent0_cnt, 0);
        chk("arst_ready", meas_ready, 1);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
